// File: rtl/div_tick_pwm.sv
// Clock-enable PWM generator: turns divider levels into tick strobes that step a
// period/duty counter whose settings are double-buffered and applied at wrap.
module div_tick_pwm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_div2,
  input  logic             clk_div4,
  input  logic [1:0]       rate_sel,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  input  logic             load,
  output logic             pwm_out,
  output logic             tick,
  output logic             wrap,
  output logic             pending
);

  localparam logic [1:0] RATE_ALL  = 2'd0;
  localparam logic [1:0] RATE_DIV2 = 2'd1;
  localparam logic [1:0] RATE_DIV4 = 2'd2;

  logic             d2_q, d2_d;
  logic             d4_q, d4_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_period_q, sh_period_d;
  logic [WIDTH-1:0] sh_duty_q, sh_duty_d;
  logic [WIDTH-1:0] act_period_q, act_period_d;
  logic [WIDTH-1:0] act_duty_q, act_duty_d;
  logic             pending_q, pending_d;
  logic             pwm_q, pwm_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic rise2, rise4, src, t, at_end;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    src          = 1'b0;
    d2_d         = clk_div2;
    d4_d         = clk_div4;
    cnt_d        = cnt_q;
    sh_period_d  = sh_period_q;
    sh_duty_d    = sh_duty_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    pending_d    = pending_q;

    // Edge registers always run, so switching rate_sel cannot fabricate a rise.
    rise2 = clk_div2 & ~d2_q;
    rise4 = clk_div4 & ~d4_q;
    case (rate_sel)
      RATE_ALL:  src = 1'b1;
      RATE_DIV2: src = rise2;
      RATE_DIV4: src = rise4;
      default:   src = 1'b0;
    endcase
    t      = enable & src;
    at_end = (cnt_q == act_period_q);

    if (!enable) begin
      cnt_d = '0;
    end else if (t) begin
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
    end

    if (t && at_end && pending_q) begin
      act_period_d = sh_period_q;
      act_duty_d   = sh_duty_q;
      pending_d    = 1'b0;
    end

    // A load on the apply cycle lands in the shadow and re-arms pending.
    if (load) begin
      if (enable) begin
        sh_period_d = period;
        sh_duty_d   = duty;
        pending_d   = 1'b1;
      end else begin
        act_period_d = period;
        act_duty_d   = duty;
        pending_d    = 1'b0;
      end
    end

    pwm_d  = enable & (cnt_q < act_duty_q);
    tick_d = t;
    wrap_d = t & at_end;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d2_q         <= 1'b0;
      d4_q         <= 1'b0;
      cnt_q        <= '0;
      sh_period_q  <= '0;
      sh_duty_q    <= '0;
      act_period_q <= '0;
      act_duty_q   <= '0;
      pending_q    <= 1'b0;
      pwm_q        <= 1'b0;
      tick_q       <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop sees pre-edge values.
      d2_q         <= d2_d;
      d4_q         <= d4_d;
      cnt_q        <= cnt_d;
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      tick_q       <= tick_d;
      wrap_q       <= wrap_d;
    end
  end

  assign pwm_out = pwm_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_div_tick_pwm.sv
// Directed bench for div_tick_pwm: outputs are compared as the vector
// {pwm_out, tick, wrap, pending} against hand-derived per-edge expectations.
module tb_div_tick_pwm;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_div2, clk_div4;
  logic [1:0] rate_sel;
  logic       enable;
  logic [7:0] period, duty;
  logic       load;
  logic       pwm_out, tick, wrap, pending;

  int total = 0;
  int bad   = 0;

  logic       div_run = 1'b0;
  logic [1:0] div_c   = 2'd0;

  div_tick_pwm #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_div2 (clk_div2),
    .clk_div4 (clk_div4),
    .rate_sel (rate_sel),
    .enable   (enable),
    .period   (period),
    .duty     (duty),
    .load     (load),
    .pwm_out  (pwm_out),
    .tick     (tick),
    .wrap     (wrap),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge; outputs are sampled 1 time unit later, the divider model
  // advances at the same point so its levels are stable before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (div_run) begin
      div_c    = div_c + 2'd1;
      clk_div2 = div_c[0];
      clk_div4 = div_c[1];
    end
  endtask

  // Disable, then load period/duty directly into the active pair.
  task automatic setup(input logic [7:0] p, input logic [7:0] d);
    enable = 1'b0;
    load   = 1'b1;
    period = p;
    duty   = d;
    step();
    load   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; clk_div2 = 1'b0; clk_div4 = 1'b0; rate_sel = 2'd0;
    enable = 1'b0; period = 8'd0; duty = 8'd0; load = 1'b0;
    step();
    step();
    total++;
    if ({pwm_out, tick, wrap, pending} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_state: got %b want 0000", {pwm_out, tick, wrap, pending});
    end
    reset = 1'b1;
  endtask

  task automatic test_basic_rate0();
    logic [3:0] exp;
    setup(8'd3, 8'd2);
    enable = 1'b1; rate_sel = 2'd0;
    for (int k = 0; k < 8; k++) begin
      step();
      exp = {((k % 4) < 2), 1'b1, ((k % 4) == 3), 1'b0};
      total++;
      if ({pwm_out, tick, wrap, pending} !== exp) begin
        bad++;
        $display("FAIL basic_rate0[%0d]: got %b want %b", k, {pwm_out, tick, wrap, pending}, exp);
      end
    end
    enable = 1'b0;
    step();
    total++;
    if ({pwm_out, tick, wrap} !== 3'b000) begin
      bad++;
      $display("FAIL enable_fall: got %b want 000", {pwm_out, tick, wrap});
    end
  endtask

  task automatic test_divider_rate4();
    logic [3:0] exp;
    logic       found;
    int         ticks;
    div_c = 2'd0; clk_div2 = 1'b0; clk_div4 = 1'b0; div_run = 1'b1;
    setup(8'd1, 8'd1);
    for (int i = 0; i < 4; i++) step();
    enable = 1'b1; rate_sel = 2'd2;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      found = tick;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL div4_first_tick: got none want tick within 8 cycles");
    end else begin
      for (int j = 0; j < 16; j++) begin
        if (j > 0) step();
        exp = {(j == 0) ? 1'b1 : (((j - 1) / 4) % 2 == 1),
               (j % 4 == 0), (j % 8 == 4), 1'b0};
        total++;
        if ({pwm_out, tick, wrap, pending} !== exp) begin
          bad++;
          $display("FAIL div4[%0d]: got %b want %b", j, {pwm_out, tick, wrap, pending}, exp);
        end
      end
    end
    rate_sel = 2'd1;
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      ticks += int'(tick);
    end
    total++;
    if (ticks != 4) begin
      bad++;
      $display("FAIL div2_tick_count: got %0d want 4", ticks);
    end
    rate_sel = 2'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({tick, wrap} !== 2'b00) begin
        bad++;
        $display("FAIL hold[%0d]: got tick/wrap %b want 00", i, {tick, wrap});
      end
    end
    div_run = 1'b0;
    rate_sel = 2'd0;
  endtask

  task automatic table_run(input string name, input logic [11:0] pw,
                           input logic [11:0] wr, input logic [11:0] pd,
                           input logic [7:0] lp [2], input logic [7:0] ld [2],
                           input int le [2]);
    logic [3:0] exp;
    for (int e = 1; e <= 12; e++) begin
      for (int n = 0; n < 2; n++) begin
        if (le[n] == e) begin
          load = 1'b1; period = lp[n]; duty = ld[n];
        end
      end
      step();
      load = 1'b0;
      exp = {pw[e-1], 1'b1, wr[e-1], pd[e-1]};
      total++;
      if ({pwm_out, tick, wrap, pending} !== exp) begin
        bad++;
        $display("FAIL %s[e%0d]: got %b want %b", name, e, {pwm_out, tick, wrap, pending}, exp);
      end
    end
  endtask

  task automatic test_shadow_update();
    logic [7:0] lp [2];
    logic [7:0] ld [2];
    int         le [2];
    lp = '{8'd7, 8'd0}; ld = '{8'd4, 8'd0}; le = '{2, 0};
    setup(8'd3, 8'd1);
    enable = 1'b1;
    table_run("shadow", 12'b0000_1111_0001, 12'b1000_0000_1000, 12'b0000_0000_0110,
              lp, ld, le);
  endtask

  task automatic test_duty_range();
    logic [3:0] exp;
    for (int r = 0; r < 2; r++) begin
      setup(8'd7, (r == 0) ? 8'd0 : 8'd9);
      enable = 1'b1;
      for (int e = 1; e <= 16; e++) begin
        step();
        exp = {(r == 1), 1'b1, (e % 8 == 0), 1'b0};
        total++;
        if ({pwm_out, tick, wrap, pending} !== exp) begin
          bad++;
          $display("FAIL duty_range%0d[e%0d]: got %b want %b", r, e,
                   {pwm_out, tick, wrap, pending}, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] lp [2];
    logic [7:0] ld [2];
    int         le [2];
    lp = '{8'd1, 8'd5}; ld = '{8'd1, 8'd3}; le = '{2, 4};
    setup(8'd3, 8'd1);
    enable = 1'b1;
    table_run("load_at_apply", 12'b0001_1101_0001, 12'b1000_0010_1000, 12'b0000_0001_1110,
              lp, ld, le);
  endtask

  task automatic test_reset_midrun();
    // Continues from the 5/3 setting left active by the previous task.
    step();
    load = 1'b1; period = 8'd2; duty = 8'd2;
    step();
    load = 1'b0;
    total++;
    if ({pwm_out, pending} !== 2'b11) begin
      bad++;
      $display("FAIL pre_reset: got pwm/pending %b want 11", {pwm_out, pending});
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({pwm_out, tick, wrap, pending} !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset: got %b want 0000", {pwm_out, tick, wrap, pending});
    end
    step();
    reset = 1'b1;
    for (int e = 0; e < 4; e++) begin
      step();
      total++;
      if ({pwm_out, tick, wrap, pending} !== 4'b0110) begin
        bad++;
        $display("FAIL post_reset[%0d]: got %b want 0110", e, {pwm_out, tick, wrap, pending});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_rate0();
    test_divider_rate4();
    test_shadow_update();
    test_duty_range();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
